// File: rtl/matrix_frame_rx.sv
// Oversampled SPI frame receiver. It commits a FRAME_BITS-bit frame to matrix only if exactly FRAME_BITS bits arrived.
// Optional SDO_ECHO_EN adds an sdo port that echoes the committed frame back while the next frame is shifted in.
module matrix_frame_rx #(
  parameter int unsigned FRAME_BITS  = 128,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  sck,
  input  logic                  sdi,
  input  logic                  load,
  output logic [FRAME_BITS-1:0] matrix,
  output logic                  frame_valid,
  output logic                  frame_error,
  output logic                  busy
`ifdef SDO_ECHO_EN
  ,
  output logic                  sdo
`endif
);

  localparam int unsigned CW = $clog2(FRAME_BITS + 2);
  localparam int unsigned FW = $clog2(SYNC_STAGES + 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(FRAME_BITS);
  localparam logic [CW-1:0] CNT_OVER = CW'(FRAME_BITS + 1);
  localparam logic [FW-1:0] FILL_MAX = FW'(SYNC_STAGES);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    COMMIT,
    ERROR
  } state_t;

  state_t state_q, state_d;

  logic [SYNC_STAGES-1:0] sck_sync, sdi_sync, load_sync;
  logic                   sck_s, sdi_s, load_s, sck_prev;
  logic                   sck_rise, sck_fall;
  logic [FW-1:0]          fill;
  logic                   armed;
  logic [CW-1:0]          bit_cnt;
  logic [FRAME_BITS-1:0]  shadow;
  logic                   shift_en, cnt_clr, commit, reject;

  assign sck_s    = sck_sync[SYNC_STAGES-1];
  assign sdi_s    = sdi_sync[SYNC_STAGES-1];
  assign load_s   = load_sync[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~sck_prev;
  assign sck_fall = ~sck_s & sck_prev;
  assign busy     = (state_q != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sck_sync  <= '0;
      sdi_sync  <= '0;
      load_sync <= '0;
      sck_prev  <= 1'b0;
    end else begin
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], sck};
      sdi_sync  <= {sdi_sync[SYNC_STAGES-2:0], sdi};
      load_sync <= {load_sync[SYNC_STAGES-2:0], load};
      sck_prev  <= sck_s;
    end
  end

  // The reset-zeroed synchronizer must fill with real samples before a low load_s counts as
  // "load seen low". This keeps a load held high through reset from restarting mid-frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fill  <= '0;
      armed <= 1'b0;
    end else begin
      if (fill != FILL_MAX) fill <= fill + 1'b1;
      if (fill == FILL_MAX && !load_s) armed <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    shift_en = 1'b0;
    cnt_clr  = 1'b0;
    commit   = 1'b0;
    reject   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (load_s && armed) begin
          state_d = SHIFT;
          cnt_clr = 1'b1;
        end
      end
      SHIFT: begin
        // A falling load takes priority over a coincident sck rise.
        if (!load_s) state_d = (bit_cnt == CNT_FULL) ? COMMIT : ERROR;
        else if (sck_rise) shift_en = 1'b1;
      end
      COMMIT: begin
        commit  = 1'b1;
        state_d = IDLE;
      end
      ERROR: begin
        reject  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bit_cnt     <= '0;
      shadow      <= '0;
      matrix      <= '0;
      frame_valid <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      frame_valid <= commit;
      frame_error <= reject;
      if (cnt_clr) begin
        bit_cnt <= '0;
      end else if (shift_en) begin
        shadow <= {shadow[FRAME_BITS-2:0], sdi_s};
        if (bit_cnt != CNT_OVER) bit_cnt <= bit_cnt + 1'b1;
      end
      if (commit) matrix <= shadow;
    end
  end

`ifdef SDO_ECHO_EN
  logic [FRAME_BITS-1:0] echo;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      echo <= '0;
      sdo  <= 1'b0;
    end else if (cnt_clr) begin
      echo <= matrix;
    end else if (state_q == SHIFT && sck_fall) begin
      sdo  <= echo[FRAME_BITS-1];
      echo <= {echo[FRAME_BITS-2:0], 1'b0};
    end
  end
`endif

endmodule

// File: tb/tb_matrix_frame_rx.sv
// Randomized self-checking bench for matrix_frame_rx; each frame's bits are kept in a queue and the expected matrix is packed from it.
// Build with +define+SDO_ECHO_EN to also check the sdo readback.
module tb_matrix_frame_rx;

  localparam int unsigned FB   = 128;
  localparam int unsigned SS   = 2;
  localparam int unsigned HALF = 5;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          sck = 1'b0;
  logic          sdi = 1'b0;
  logic          load = 1'b0;
  logic [FB-1:0] matrix;
  logic          frame_valid, frame_error, busy;
`ifdef SDO_ECHO_EN
  logic          sdo;
`endif

  matrix_frame_rx #(
    .FRAME_BITS (FB),
    .SYNC_STAGES(SS)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .sck        (sck),
    .sdi        (sdi),
    .load       (load),
    .matrix     (matrix),
    .frame_valid(frame_valid),
    .frame_error(frame_error),
    .busy       (busy)
`ifdef SDO_ECHO_EN
    ,
    .sdo        (sdo)
`endif
  );

  always #5 clk = ~clk;

  int unsigned n_total = 0;
  int unsigned n_pass  = 0;
  int unsigned vcnt    = 0;
  int unsigned ecnt    = 0;
  logic [FB-1:0] exp_matrix = '0;

  always @(negedge clk) begin
    if (frame_valid === 1'b1) vcnt++;
    if (frame_error === 1'b1) ecnt++;
  end

  task automatic check(input string tag, input logic [FB-1:0] obs, input logic [FB-1:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic clks(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    sdi = b;
    clks(HALF);
    sck = 1'b1;
    clks(HALF);
    sck = 1'b0;
  endtask

  task automatic run_frame(input logic [FB-1:0] data, input int unsigned n, input string tag);
    logic          q[$];
    logic [FB-1:0] prev;
    logic [FB-1:0] packed_bits;
    logic          b;
    int unsigned   v0, e0;
    prev = exp_matrix;
    v0   = vcnt;
    e0   = ecnt;
    check({tag, "_busy_idle"}, FB'(busy), FB'(0));
    load = 1'b1;
    clks(5);
    for (int unsigned i = 0; i < n; i++) begin
`ifdef SDO_ECHO_EN
      if (i >= 1 && i <= FB) check({tag, "_sdo"}, FB'(sdo), FB'(prev[FB-i]));
`endif
      b = (i < FB) ? data[FB-1-i] : 1'($urandom);
      q.push_back(b);
      send_bit(b);
    end
    clks(HALF);
`ifdef SDO_ECHO_EN
    if (n >= 1 && n <= FB) check({tag, "_sdo_last"}, FB'(sdo), FB'(prev[FB-n]));
`endif
    if (n > 0) check({tag, "_busy_shift"}, FB'(busy), FB'(1));
    load = 1'b0;
    clks(SS + 1);
    check({tag, "_early_matrix"}, matrix, prev);
    check({tag, "_early_valid"}, FB'(frame_valid), FB'(0));
    clks(1);
    if (q.size() == FB) begin
      packed_bits = '0;
      foreach (q[k]) packed_bits = {packed_bits[FB-2:0], q[k]};
      exp_matrix = packed_bits;
      check({tag, "_valid"}, FB'(frame_valid), FB'(1));
    end else begin
      check({tag, "_error"}, FB'(frame_error), FB'(1));
    end
    check({tag, "_matrix"}, matrix, exp_matrix);
    clks(2);
    check({tag, "_nvalid"}, FB'(vcnt - v0), FB'(q.size() == FB));
    check({tag, "_nerror"}, FB'(ecnt - e0), FB'(q.size() != FB));
    check({tag, "_busy_after"}, FB'(busy), FB'(0));
  endtask

  function automatic logic [FB-1:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    #1;
    check("rst_matrix", matrix, '0);
    check("rst_valid", FB'(frame_valid), FB'(0));
    check("rst_busy", FB'(busy), FB'(0));
    clks(3);
    reset = 1'b0;
    clks(4);

    run_frame(128'h8000_0000_0000_0001_FFFF_0000_A5A5_5A5A, 128, "t2");
    run_frame(rnd128(), 127, "t3_under");
    run_frame(rnd128(), 129, "t3_over");
    run_frame(rnd128(), 0, "zero");
    run_frame('1, 128, "t4_ones");
    run_frame(128'h0F, 128, "t4_0f");

    // Asynchronous reset while idle with a committed frame.
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("t1_matrix", matrix, '0);
    check("t1_valid", FB'(frame_valid), FB'(0));
    check("t1_error", FB'(frame_error), FB'(0));
    check("t1_busy", FB'(busy), FB'(0));
    exp_matrix = '0;
    clks(2);
    reset = 1'b0;
    clks(4);

    run_frame(rnd128(), 128, "pre_t5");
    load = 1'b1;
    clks(5);
    for (int unsigned i = 0; i < 64; i++) send_bit(1'($urandom));
    #2 reset = 1'b1;
    #1;
    check("t5_matrix", matrix, '0);
    check("t5_busy", FB'(busy), FB'(0));
    exp_matrix = '0;
    clks(2);
    reset = 1'b0;
    clks(8);
    check("t5_held_load", FB'(busy), FB'(0));
    load = 1'b0;
    clks(6);
    run_frame(128'h1234, 128, "t5_frame");

    run_frame({2'b11, 124'h0, 2'b11}, 128, "t6_seed");
    run_frame(rnd128(), 128, "t6_echo");

    for (int unsigned r = 0; r < 6; r++) begin
      int unsigned n;
      case ($urandom_range(0, 3))
        0:       n = 128;
        1:       n = 127;
        2:       n = 129;
        default: n = $urandom_range(1, 130);
      endcase
      run_frame(rnd128(), n, "rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
